bp_be_int_pipe_arb: RTL

BP_BE_INT_PIPE_ARB -- requirements
Module: bp_be_int_pipe_arb

---
 rtl/bp_be_int_pipe_arb.sv | 70 +++++++
 1 files changed

// File: rtl/bp_be_int_pipe_arb.sv
// bp_be_int_pipe_arb: two-requester arbiter feeding a one-entry registered issue stage of the integer pipe
// Ports:
//   clk_i, reset_i                     clock, asynchronous active-high reset
//   req0_v_i/req0_data_i/req0_ready_o  replay source (high priority) valid/packet/accept
//   req1_v_i/req1_data_i/req1_ready_o  dispatch source (low priority, starvation-protected)
//   flush_i                            squash held and incoming packets
//   pipe_v_o/pipe_data_o/pipe_src_o    registered issue packet, valid and source index
//   pipe_ready_i                       integer pipe consumes the held packet
module bp_be_int_pipe_arb #(
    parameter int payload_width_p = 64,
    parameter int starve_limit_p  = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       req0_v_i,
    input  logic [payload_width_p-1:0] req0_data_i,
    output logic                       req0_ready_o,
    input  logic                       req1_v_i,
    input  logic [payload_width_p-1:0] req1_data_i,
    output logic                       req1_ready_o,
    input  logic                       flush_i,
    output logic                       pipe_v_o,
    output logic [payload_width_p-1:0] pipe_data_o,
    output logic                       pipe_src_o,
    input  logic                       pipe_ready_i
);
    localparam logic [3:0] LIMIT = 4'(starve_limit_p);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e                     r_state;
    logic [payload_width_p-1:0] r_data;
    logic                       r_src;
    logic [3:0]                 r_starve_cnt;

    logic w_load, w_forced, w_gnt0, w_gnt1;

    // Reset is folded into load so neither requester sees ready while reset is held.
    assign w_load   = ~flush_i & ~reset_i & ((r_state == EMPTY) | pipe_ready_i);
    assign w_forced = r_starve_cnt == LIMIT;
    assign w_gnt1   = req1_v_i & (w_forced | ~req0_v_i);
    assign w_gnt0   = req0_v_i & ~w_gnt1;

    assign req0_ready_o = w_load & w_gnt0;
    assign req1_ready_o = w_load & w_gnt1;
    assign pipe_v_o     = r_state == FULL;
    assign pipe_data_o  = r_data;
    assign pipe_src_o   = r_src;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= EMPTY;
            r_data       <= '0;
            r_src        <= 1'b0;
            r_starve_cnt <= '0;
        end else if (flush_i) begin
            r_state      <= EMPTY;
            r_starve_cnt <= '0;
        end else if (w_load) begin
            r_state <= (w_gnt0 | w_gnt1) ? FULL : EMPTY;
            if (w_gnt0 | w_gnt1) begin
                r_data <= w_gnt1 ? req1_data_i : req0_data_i;
                r_src  <= w_gnt1;
            end
            // req1 waiting but losing to req0 counts toward a forced grant.
            r_starve_cnt <= (w_gnt1 | ~req1_v_i) ? 4'd0
                          : w_forced ? r_starve_cnt : r_starve_cnt + 4'd1;
        end
    end
endmodule
